// File: rtl/fpu_exec_ctrl.sv
// fpu_exec_ctrl: sequences one decoded FPU op at a time through fixed-latency units and retires its result
module fpu_exec_ctrl #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 12,
  parameter int LAT_CVT  = 2,
  parameter int LAT_CMP  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic [6:0]  alu_control,
  input  logic        fpu_reg_write_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] fadd_res,
  input  logic [31:0] fmul_res,
  input  logic [31:0] fdiv_res,
  input  logic [31:0] fsqrt_res,
  input  logic [31:0] fcvtws_res,
  input  logic [31:0] fcvtsw_res,
  input  logic        fcmp_res,
  output logic [6:0]  unit_start,
  output logic [6:0]  unit_op,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        fpu_wr,
  output logic        int_wr,
  output logic        illegal
);
  localparam logic [6:0] FADD = 7'h40, FSUB = 7'h41, FMUL = 7'h42, FDIV = 7'h43;
  localparam logic [6:0] FEQ = 7'h44, FLT = 7'h45, FLE = 7'h46, FSQRT = 7'h47;
  localparam logic [6:0] FCVTWS = 7'h4F, FCVTSW = 7'h57;
  localparam logic [6:0] FMV = 7'h21, FSGNJ = 7'h22, FSGNJN = 7'h23, ADD = 7'h00;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [4:0]  lat;
  logic [6:0]  start_nx;
  logic        acc, wc, known;
  logic [31:0] res;

  assign start_nx = {alu_control inside {FEQ, FLT, FLE}, alu_control == FCVTSW,
                     alu_control == FCVTWS, alu_control == FSQRT, alu_control == FDIV,
                     alu_control == FMUL, alu_control inside {FADD, FSUB}};
  assign lat = start_nx[0] ? 5'(LAT_ADD)  : start_nx[1] ? 5'(LAT_MUL) :
               start_nx[2] ? 5'(LAT_DIV)  : start_nx[3] ? 5'(LAT_SQRT) :
               (start_nx[4] | start_nx[5]) ? 5'(LAT_CVT) :
               start_nx[6] ? 5'(LAT_CMP)  : 5'd1;
  assign acc = issue_valid & ~flush & (state != WAIT);

  // cnt holds the WAIT cycles still to go after the current one
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (flush) state_nx = IDLE;
    else if (acc) begin
      state_nx = (lat == 5'd1) ? DONE : WAIT;
      cnt_nx = 4'(lat - 5'd2);
    end else if (state == WAIT) begin
      state_nx = (cnt == 4'd0) ? DONE : WAIT;
      cnt_nx = cnt - 4'd1;
    end else if (state == DONE) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      unit_start <= '0;
      unit_op <= '0;
      op_a <= '0;
      op_b <= '0;
      rd_out <= '0;
      wc <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      unit_start <= acc ? start_nx : 7'd0;
      if (acc) begin
        unit_op <= alu_control;
        op_a <= src_a;
        op_b <= src_b;
        rd_out <= rd_in;
        wc <= fpu_reg_write_in;
      end
    end
  end

  always_comb begin
    known = unit_op inside {FADD, FSUB, FMUL, FDIV, FEQ, FLT, FLE, FSQRT, FCVTWS, FCVTSW,
                            FMV, FSGNJ, FSGNJN, ADD};
    res = (unit_op == FADD || unit_op == FSUB) ? fadd_res :
          (unit_op == FMUL)   ? fmul_res :
          (unit_op == FDIV)   ? fdiv_res :
          (unit_op == FSQRT)  ? fsqrt_res :
          (unit_op == FCVTWS) ? fcvtws_res :
          (unit_op == FCVTSW) ? fcvtsw_res :
          (unit_op inside {FEQ, FLT, FLE}) ? {31'd0, fcmp_res} :
          (unit_op == FMV)    ? op_a :
          (unit_op == FSGNJ)  ? {op_b[31], op_a[30:0]} :
          (unit_op == FSGNJN) ? {~op_b[31], op_a[30:0]} :
          (unit_op == ADD)    ? op_a + op_b : 32'd0;
  end

  assign stall = (state == WAIT);
  assign result_valid = (state == DONE);
  assign result = result_valid ? res : 32'd0;
  assign fpu_wr = result_valid & wc;
  assign int_wr = result_valid & ~wc;
  assign illegal = result_valid & ~known;
endmodule

// File: tb/tb_fpu_exec_ctrl.sv
// tb_fpu_exec_ctrl: random and directed issue streams scored against a cycle-indexed model of the sequencer
module tb_fpu_exec_ctrl;
  localparam int LA = 3, LM = 2, LD = 12, LS = 12, LC = 2, LP = 1;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, fpu_reg_write_in, fcmp_res;
  logic [6:0]  alu_control, unit_start, unit_op;
  logic [4:0]  rd_in, rd_out;
  logic [31:0] src_a, src_b, fadd_res, fmul_res, fdiv_res, fsqrt_res, fcvtws_res, fcvtsw_res;
  logic [31:0] op_a, op_b, result;
  logic        stall, result_valid, fpu_wr, int_wr, illegal;

  fpu_exec_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .alu_control(alu_control),
    .fpu_reg_write_in(fpu_reg_write_in), .rd_in(rd_in), .src_a(src_a), .src_b(src_b),
    .fadd_res(fadd_res), .fmul_res(fmul_res), .fdiv_res(fdiv_res), .fsqrt_res(fsqrt_res),
    .fcvtws_res(fcvtws_res), .fcvtsw_res(fcvtsw_res), .fcmp_res(fcmp_res),
    .unit_start(unit_start), .unit_op(unit_op), .op_a(op_a), .op_b(op_b), .stall(stall),
    .result_valid(result_valid), .result(result), .rd_out(rd_out), .fpu_wr(fpu_wr),
    .int_wr(int_wr), .illegal(illegal));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wc;
    logic        ill;
    logic [31:0] a;
  } exp_t;

  exp_t        q[$];
  logic [6:0]  st_at[int];
  bit          stall_at[int];
  int          cyc = 0, res_cyc = -1, checks = 0, errors = 0;
  bit          en = 0;
  logic [6:0]  codes[16] = '{7'h40, 7'h41, 7'h42, 7'h43, 7'h44, 7'h45, 7'h46, 7'h47,
                             7'h4F, 7'h57, 7'h21, 7'h22, 7'h23, 7'h00, 7'h7F, 7'h10};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input logic [6:0] op);
    case (op)
      7'h40, 7'h41: return LA;
      7'h42: return LM;
      7'h43: return LD;
      7'h47: return LS;
      7'h4F, 7'h57: return LC;
      7'h44, 7'h45, 7'h46: return LP;
      default: return 1;
    endcase
  endfunction

  function automatic logic [6:0] start_of(input logic [6:0] op);
    case (op)
      7'h40, 7'h41: return 7'h01;
      7'h42: return 7'h02;
      7'h43: return 7'h04;
      7'h47: return 7'h08;
      7'h4F: return 7'h10;
      7'h57: return 7'h20;
      7'h44, 7'h45, 7'h46: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return start_of(op) != 0 || op == 7'h21 || op == 7'h22 || op == 7'h23 || op == 7'h00;
  endfunction

  function automatic logic [31:0] exp_res(input logic [6:0] op, input logic [31:0] a, b);
    case (op)
      7'h40, 7'h41: return fadd_res;
      7'h42: return fmul_res;
      7'h43: return fdiv_res;
      7'h47: return fsqrt_res;
      7'h4F: return fcvtws_res;
      7'h57: return fcvtsw_res;
      7'h44, 7'h45, 7'h46: return {31'd0, fcmp_res};
      7'h21: return a;
      7'h22: return {b[31], a[30:0]};
      7'h23: return {~b[31], a[30:0]};
      7'h00: return a + b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // drives one cycle of inputs and advances the reference model for that cycle
  task automatic step(input bit r, fl, iv, input logic [6:0] op, input bit wr,
                      input logic [4:0] rd, input logic [31:0] a, b);
    int l;
    @(posedge clk);
    #1;
    rst = r; flush = fl; issue_valid = iv; alu_control = op;
    fpu_reg_write_in = wr; rd_in = rd; src_a = a; src_b = b;
    if (r || fl) begin
      if (res_cyc > cyc) begin
        void'(q.pop_back());
        res_cyc = -1;
      end
      for (int k = cyc + 1; k <= cyc + 20; k++) if (stall_at.exists(k)) stall_at.delete(k);
    end else if (iv && (res_cyc < 0 || cyc >= res_cyc)) begin
      l = lat_of(op);
      res_cyc = cyc + l;
      q.push_back('{cyc + l, exp_res(op, a, b), rd, wr, !legal(op), a});
      if (start_of(op) != 0) st_at[cyc + 1] = start_of(op);
      for (int k = 1; k < l; k++) stall_at[cyc + k] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 7'h00, 0, 5'd0, 32'd0, 32'd0);
  endtask

  always @(negedge clk) if (en) begin
    exp_t e;
    chk("unit_start", 32'(unit_start), st_at.exists(cyc) ? 32'(st_at[cyc]) : 32'd0);
    chk("stall", 32'(stall), 32'(stall_at.exists(cyc)));
    if (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      chk("missing_result", 32'(e.due), 32'(cyc));
    end
    if (result_valid) begin
      if (q.size() == 0) chk("spurious_result", 32'(result_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("result_cycle", 32'(cyc), 32'(e.due));
        chk("result", result, e.res);
        chk("rd_out", 32'(rd_out), 32'(e.rd));
        chk("fpu_wr", 32'(fpu_wr), 32'(e.wc));
        chk("int_wr", 32'(int_wr), 32'(!e.wc));
        chk("illegal", 32'(illegal), 32'(e.ill));
        chk("op_a", op_a, e.a);
      end
    end
  end

  initial begin
    rst = 1; flush = 0; issue_valid = 1; alu_control = 7'h40; fpu_reg_write_in = 0;
    rd_in = 0; src_a = 0; src_b = 0; fcmp_res = 1;
    fadd_res = 32'h3FC00000; fmul_res = 32'h40400000; fdiv_res = 32'h40000000;
    fsqrt_res = 32'h3FB504F3; fcvtws_res = 32'h00000005; fcvtsw_res = 32'h40A00000;
    step(1, 0, 1, 7'h40, 1, 5'd3, 32'h1, 32'h2);
    step(1, 0, 1, 7'h43, 1, 5'd3, 32'h1, 32'h2);
    step(0, 0, 0, 7'h00, 0, 5'd0, 32'd0, 32'd0);
    en = 1;
    @(negedge clk);
    chk("reset_outputs", 32'({unit_start, stall, result_valid, fpu_wr, int_wr, illegal}), 32'd0);
    chk("reset_regs", {result | op_a | op_b}, 32'd0);
    chk("reset_opcode_rd", 32'({unit_op, rd_out}), 32'd0);
    step(0, 0, 1, 7'h23, 1, 5'd3, 32'h3F800000, 32'h00000000);
    idle(2);
    step(0, 0, 1, 7'h43, 0, 5'd7, 32'h40800000, 32'h40000000);
    idle(4);
    step(0, 0, 1, 7'h40, 1, 5'd9, 32'h1, 32'h2);
    idle(8);
    step(0, 0, 1, 7'h44, 0, 5'd4, 32'h1, 32'h1);
    idle(2);
    step(0, 0, 1, 7'h42, 1, 5'd5, 32'h1, 32'h2);
    idle(1);
    step(0, 0, 1, 7'h40, 1, 5'd6, 32'h3, 32'h4);
    idle(5);
    step(0, 0, 1, 7'h43, 1, 5'd8, 32'h5, 32'h6);
    idle(3);
    step(0, 1, 0, 7'h00, 0, 5'd0, 32'd0, 32'd0);
    step(0, 0, 1, 7'h21, 0, 5'd2, 32'h12345678, 32'h0);
    idle(2);
    step(0, 0, 1, 7'h7F, 1, 5'd1, 32'hFFFFFFFF, 32'h1);
    idle(2);
    fcmp_res = 1'($urandom);
    fadd_res = $urandom; fmul_res = $urandom; fdiv_res = $urandom;
    fsqrt_res = $urandom; fcvtws_res = $urandom; fcvtsw_res = $urandom;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, 1'($urandom),
           codes[$urandom_range(0, 15)], 1'($urandom), 5'($urandom), $urandom, $urandom);
    idle(20);
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
